// File: rtl/serial_slice_adder_ctrl.sv
// Serial add/subtract sequencer: one 2-bit slice per clock through a single twoBitAdder,
// LSB slice first, with valid/ready handshakes on the operand and result sides.

module twoBitAdder (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  input  logic       i_cin,
  output logic [1:0] o_sum,
  output logic       o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {2'b00, i_cin};
endmodule

module serial_slice_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH / 2 - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
    $error("serial_slice_adder_ctrl: WIDTH must be even and at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_last;

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_s;
  logic [CNTW-1:0]  r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [1:0] w_sum;
  logic       w_slice_cout;

  // Operands shift right each slice, so the active slice is always in bits [1:0]
  // and the original MSBs sit in bit 1 on the final slice.
  twoBitAdder u_slice (
    .i_a    (r_op_a[1:0]),
    .i_b    (r_op_b[1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_slice_cout)
  );

  assign w_last = (r_state == RUN) && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN:  if (r_cnt == LAST) w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_op_a  <= a;
      r_op_b  <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
      r_s     <= '0;
    end else if (r_state == RUN) begin
      r_op_a  <= WIDTH'({2'b00, r_op_a} >> 2);
      r_op_b  <= WIDTH'({2'b00, r_op_b} >> 2);
      // Each new slice enters at the top; after WIDTH/2 slices slice 0 lands in [1:0].
      r_s     <= WIDTH'({w_sum, r_s} >> 2);
      r_carry <= w_slice_cout;
      if (w_last) begin
        r_cout <= w_slice_cout;
        r_ovf  <= (r_op_a[1] == r_op_b[1]) && (w_sum[1] != r_op_a[1]);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_slice_adder_ctrl.sv
// Bench for serial_slice_adder_ctrl: directed and random operations on a WIDTH=8 instance,
// plus the WIDTH=2 corner, checked against an integer-arithmetic reference model.

module tb_serial_slice_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, sub8 = 1'b0;
  logic       out_valid8, out_ready8 = 1'b0, cout8, ovf8;
  logic [7:0] a8 = '0, b8 = '0, s8;

  logic       in_valid2 = 1'b0, in_ready2, cin2 = 1'b0, sub2 = 1'b0;
  logic       out_valid2, out_ready2 = 1'b0, cout2, ovf2;
  logic [1:0] a2 = '0, b2 = '0, s2;

  int n_chk  = 0;
  int n_pass = 0;

  serial_slice_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  serial_slice_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .out_valid(out_valid2), .out_ready(out_ready2), .s(s2), .cout(cout2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain modular sum for s/cout, signed-range test for overflow.
  function automatic void model8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                 input logic sub, output logic [7:0] s, output logic c,
                                 output logic o);
    int ub, full, sa, sb, r;
    logic [7:0] nb;
    nb   = ~b;
    ub   = sub ? int'(nb) : int'(b);
    full = int'(a) + ub + (sub ? 1 : int'(cin));
    s    = full[7:0];
    c    = full[8];
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    r    = sub ? (sa - sb) : (sa + sb + int'(cin));
    o    = (r < -128) || (r > 127);
  endfunction

  // Called at #1 after an edge; returns at #1 after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int budget = 0;
    while (!in_ready8 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready8) begin
      check("issue_timeout", 32'd0, 32'd1);
      return;
    end
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic collect8(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    int lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_s"}, s8, es);
    check({tag, "_cout"}, cout8, ec);
    check({tag, "_ovf"}, ovf8, eo);
  endtask

  task automatic release8(input string tag);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check({tag, "_rel_out_valid"}, out_valid8, 1'b0);
    check({tag, "_rel_in_ready"}, in_ready8, 1'b1);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] es;
    logic       ec, eo;
  } vec_t;

  vec_t dir[5];

  initial begin
    logic [7:0] es, hs;
    logic       ec, eo, hc, ho;
    dir[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    dir[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    dir[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    dir[3] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
    dir[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

    #23 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready8, 1'b1);
    check("rst_out_valid", out_valid8, 1'b0);
    check("rst_s", s8, 8'h00);
    check("rst_cout", cout8, 1'b0);
    check("rst_ovf", ovf8, 1'b0);

    foreach (dir[i]) begin
      issue8(dir[i].a, dir[i].b, dir[i].cin, dir[i].sub);
      check("dir_in_ready_busy", in_ready8, 1'b0);
      collect8($sformatf("dir%0d", i), dir[i].es, dir[i].ec, dir[i].eo);
      release8("dir");
    end

    // Back-pressure: result must hold while new operands wait upstream.
    issue8(8'h12, 8'h34, 1'b1, 1'b0);
    model8(8'h12, 8'h34, 1'b1, 1'b0, es, ec, eo);
    collect8("bp_first", es, ec, eo);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; sub8 = 1'b1; in_valid8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_s", s8, es);
      check("bp_hold_cout", cout8, ec);
      check("bp_hold_ovf", ovf8, eo);
      check("bp_hold_in_ready", in_ready8, 1'b0);
      check("bp_hold_out_valid", out_valid8, 1'b1);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("bp_idle_in_ready", in_ready8, 1'b1);
    check("bp_idle_out_valid", out_valid8, 1'b0);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("bp_accepted", in_ready8, 1'b0);
    model8(8'h77, 8'h11, 1'b0, 1'b1, es, ec, eo);
    collect8("bp_second", es, ec, eo);
    release8("bp");

    // Asynchronous reset two clocks into RUN.
    issue8(8'hAA, 8'h55, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #4 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready8, 1'b1);
    check("mid_rst_out_valid", out_valid8, 1'b0);
    check("mid_rst_s", s8, 8'h00);
    check("mid_rst_cout", cout8, 1'b0);
    check("mid_rst_ovf", ovf8, 1'b0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready8, 1'b1);
    check("post_rst_out_valid", out_valid8, 1'b0);
    issue8(8'h01, 8'h02, 1'b0, 1'b0);
    collect8("post_rst", 8'h03, 1'b0, 1'b0);
    release8("post_rst");

    // Random operations with random consumer stalls.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra, rb;
      logic       rc, rs;
      int         hold;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      hold = $urandom_range(0, 3);
      model8(ra, rb, rc, rs, es, ec, eo);
      issue8(ra, rb, rc, rs);
      collect8("rnd", es, ec, eo);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        hs = s8; hc = cout8; ho = ovf8;
        check("rnd_hold", {hs, hc, ho}, {es, ec, eo});
      end
      release8("rnd");
    end

    // WIDTH=2 corner: result one clock after acceptance.
    a2 = 2'b11; b2 = 2'b01; cin2 = 1'b0; sub2 = 1'b0; in_valid2 = 1'b1;
    check("w2_in_ready", in_ready2, 1'b1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    check("w2_out_valid_early", out_valid2, 1'b0);
    @(posedge clk); #1;
    check("w2_out_valid", out_valid2, 1'b1);
    check("w2_s", s2, 2'b00);
    check("w2_cout", cout2, 1'b1);
    check("w2_ovf", ovf2, 1'b0);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    check("w2_rel_in_ready", in_ready2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
